// File: rtl/exe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : exe_pkg
// Brief    : Execute-stage operation classes, operation codes and divider states.
// Revision : 1.0
// ============================================================================
package exe_pkg;

    typedef enum logic [2:0] {
        ALU_SEL_NOP    = 3'd0,
        ALU_SEL_LOGIC  = 3'd1,
        ALU_SEL_SHIFT  = 3'd2,
        ALU_SEL_ARITH  = 3'd3,
        ALU_SEL_MOVE   = 3'd4,
        ALU_SEL_MULDIV = 3'd5
    } alu_sel_e;

    localparam logic [7:0] ALU_OP_AND   = 8'h24;
    localparam logic [7:0] ALU_OP_OR    = 8'h25;
    localparam logic [7:0] ALU_OP_XOR   = 8'h26;
    localparam logic [7:0] ALU_OP_NOR   = 8'h27;
    localparam logic [7:0] ALU_OP_LUI   = 8'h5C;
    localparam logic [7:0] ALU_OP_SLL   = 8'h7C;
    localparam logic [7:0] ALU_OP_SRL   = 8'h02;
    localparam logic [7:0] ALU_OP_SRA   = 8'h03;
    localparam logic [7:0] ALU_OP_ADD   = 8'h20;
    localparam logic [7:0] ALU_OP_ADDU  = 8'h21;
    localparam logic [7:0] ALU_OP_SUB   = 8'h22;
    localparam logic [7:0] ALU_OP_SUBU  = 8'h23;
    localparam logic [7:0] ALU_OP_SLT   = 8'h2A;
    localparam logic [7:0] ALU_OP_SLTU  = 8'h2B;
    localparam logic [7:0] ALU_OP_MFHI  = 8'h10;
    localparam logic [7:0] ALU_OP_MTHI  = 8'h11;
    localparam logic [7:0] ALU_OP_MFLO  = 8'h12;
    localparam logic [7:0] ALU_OP_MTLO  = 8'h13;
    localparam logic [7:0] ALU_OP_MULT  = 8'h18;
    localparam logic [7:0] ALU_OP_MULTU = 8'h19;
    localparam logic [7:0] ALU_OP_DIV   = 8'h1A;
    localparam logic [7:0] ALU_OP_DIVU  = 8'h1B;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Magnitude of a two's-complement value; 0x80000000 maps to itself, read as unsigned 2^31.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/exe_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : exe_stage_if
// Brief    : ID/EXE-facing inputs and EXE/MEM-facing outputs of the execute stage.
// Revision : 1.0
// ============================================================================
interface exe_stage_if;
    logic                 flush_i;
    logic                 stall_i;
    exe_pkg::alu_sel_e    exe_alu_sel_i;
    logic [7:0]           exe_alu_op_i;
    logic [31:0]          exe_reg1_i;
    logic [31:0]          exe_reg2_i;
    logic                 exe_wreg_i;
    logic [4:0]           exe_wd_i;
    logic                 exe_mt_hi_i;
    logic                 exe_mt_lo_i;
    logic                 exe_mf_hi_i;
    logic                 exe_mf_lo_i;
    logic                 exe_rmem_i;
    logic                 exe_wmem_i;
    logic [31:0]          exe_mem_io_addr_i;
    logic [31:0]          hi_i;
    logic [31:0]          lo_i;
    logic                 wreg_o;
    logic [4:0]           wd_o;
    logic [31:0]          wdata_o;
    logic                 whilo_o;
    logic [31:0]          hi_o;
    logic [31:0]          lo_o;
    logic                 rmem_o;
    logic                 wmem_o;
    logic [31:0]          mem_io_addr_o;
    logic [31:0]          mem_wdata_o;
    logic                 stall_req_o;
    logic                 ov_o;

    modport slave (
        input  flush_i, stall_i, exe_alu_sel_i, exe_alu_op_i, exe_reg1_i, exe_reg2_i,
               exe_wreg_i, exe_wd_i, exe_mt_hi_i, exe_mt_lo_i, exe_mf_hi_i, exe_mf_lo_i,
               exe_rmem_i, exe_wmem_i, exe_mem_io_addr_i, hi_i, lo_i,
        output wreg_o, wd_o, wdata_o, whilo_o, hi_o, lo_o, rmem_o, wmem_o,
               mem_io_addr_o, mem_wdata_o, stall_req_o, ov_o
    );

    modport master (
        output flush_i, stall_i, exe_alu_sel_i, exe_alu_op_i, exe_reg1_i, exe_reg2_i,
               exe_wreg_i, exe_wd_i, exe_mt_hi_i, exe_mt_lo_i, exe_mf_hi_i, exe_mf_lo_i,
               exe_rmem_i, exe_wmem_i, exe_mem_io_addr_i, hi_i, lo_i,
        input  wreg_o, wd_o, wdata_o, whilo_o, hi_o, lo_o, rmem_o, wmem_o,
               mem_io_addr_o, mem_wdata_o, stall_req_o, ov_o
    );
endinterface
`default_nettype wire

// File: rtl/exe_stage_div_iter.sv
`default_nettype none
// ============================================================================
// Module   : div_iter
// Brief    : Iterative radix-2 restoring divider (signed/unsigned) with FSM.
// Revision : 1.0
// ============================================================================
module div_iter
    import exe_pkg::*;
#(
    parameter int DIV_STEPS = 32
)
(
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        start,
    input  wire logic        abort,
    input  wire logic        hold,
    input  wire logic        signed_op,
    input  wire logic [31:0] dividend,
    input  wire logic [31:0] divisor,
    output logic             stall_req,
    output logic             done,
    output logic [31:0]      quotient,
    output logic [31:0]      remainder
);
    localparam logic [4:0] C_LAST = 5'(DIV_STEPS - 1);

    div_state_e  r_state;
    div_state_e  w_next;
    logic [4:0]  r_cnt;
    logic [63:0] r_rq;
    logic [31:0] r_divisor;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [32:0] w_part;
    logic [31:0] w_sub;
    logic [63:0] w_step;

    always_ff @(posedge clk) begin
        if (rst) r_state <= DIV_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            DIV_IDLE: if (start && !abort) w_next = (divisor == 32'd0) ? DIV_DONE : DIV_BUSY;
            DIV_BUSY: if (abort) w_next = DIV_IDLE;
                      else if (r_cnt == C_LAST) w_next = DIV_DONE;
            DIV_DONE: if (abort || !hold) w_next = DIV_IDLE;
            default:  w_next = DIV_IDLE;
        endcase
    end

    always_comb begin
        stall_req = !abort && ((r_state == DIV_IDLE && start) || r_state == DIV_BUSY);
        done      = !abort && (r_state == DIV_DONE);
        quotient  = r_neg_q ? (32'd0 - r_rq[31:0])  : r_rq[31:0];
        remainder = r_neg_r ? (32'd0 - r_rq[63:32]) : r_rq[63:32];
    end

    // Partial remainder is always below the divisor, so the subtraction fits in 32 bits.
    always_comb begin
        w_part = r_rq[63:31];
        w_sub  = w_part[31:0] - r_divisor;
        w_step = (w_part >= {1'b0, r_divisor}) ? {w_sub, r_rq[30:0], 1'b1}
                                               : {w_part[31:0], r_rq[30:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= 5'd0;
            r_rq      <= 64'd0;
            r_divisor <= 32'd0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
        end else if (r_state == DIV_IDLE && start && !abort) begin
            r_cnt <= 5'd0;
            if (divisor == 32'd0) begin
                r_rq      <= {dividend, 32'hFFFF_FFFF};
                r_divisor <= 32'd0;
                r_neg_q   <= 1'b0;
                r_neg_r   <= 1'b0;
            end else begin
                r_rq      <= {32'd0, abs32(dividend, signed_op)};
                r_divisor <= abs32(divisor, signed_op);
                r_neg_q   <= signed_op && (dividend[31] ^ divisor[31]);
                r_neg_r   <= signed_op && dividend[31];
            end
        end else if (r_state == DIV_BUSY) begin
            r_rq  <= w_step;
            r_cnt <= r_cnt + 5'd1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/exe_stage.sv
`default_nettype none
// ============================================================================
// Module   : exe_stage
// Brief    : MIPS execute stage: ALU, shifter, MULT, HI/LO moves, iterative DIV.
//            Build option EXE_OVERFLOW_TRAP_EN enables signed ADD/SUB overflow.
// Revision : 1.0
// ============================================================================
module exe_stage
    import exe_pkg::*;
#(
    parameter int DIV_STEPS = 32
)
(
    input  wire logic   clk,
    input  wire logic   rst,
    exe_stage_if.slave  bus
);
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [31:0] w_logic;
    logic [31:0] w_shift;
    logic [31:0] w_arith;
    logic [31:0] w_sum;
    logic [31:0] w_diff;
    logic [63:0] w_prod;
    logic        w_ov;
    logic        w_is_div;
    logic        w_div_stall;
    logic        w_div_done;
    logic [31:0] w_div_q;
    logic [31:0] w_div_r;

    assign w_a      = bus.exe_reg1_i;
    assign w_b      = bus.exe_reg2_i;
    assign w_sum    = w_a + w_b;
    assign w_diff   = w_a - w_b;
    assign w_is_div = (bus.exe_alu_sel_i == ALU_SEL_MULDIV) &&
                      (bus.exe_alu_op_i == ALU_OP_DIV || bus.exe_alu_op_i == ALU_OP_DIVU);

    div_iter #(.DIV_STEPS(DIV_STEPS)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (w_is_div),
        .abort     (bus.flush_i | rst),
        .hold      (bus.stall_i),
        .signed_op (bus.exe_alu_op_i == ALU_OP_DIV),
        .dividend  (w_a),
        .divisor   (w_b),
        .stall_req (w_div_stall),
        .done      (w_div_done),
        .quotient  (w_div_q),
        .remainder (w_div_r)
    );

    always_comb begin
        w_logic = 32'd0;
        w_shift = 32'd0;
        w_arith = 32'd0;
        case (bus.exe_alu_op_i)
            ALU_OP_AND:  w_logic = w_a & w_b;
            ALU_OP_OR:   w_logic = w_a | w_b;
            ALU_OP_XOR:  w_logic = w_a ^ w_b;
            ALU_OP_NOR:  w_logic = ~(w_a | w_b);
            ALU_OP_LUI:  w_logic = {w_b[15:0], 16'd0};
            default:     w_logic = 32'd0;
        endcase
        case (bus.exe_alu_op_i)
            ALU_OP_SLL:  w_shift = w_b << w_a[4:0];
            ALU_OP_SRL:  w_shift = w_b >> w_a[4:0];
            ALU_OP_SRA:  w_shift = $signed(w_b) >>> w_a[4:0];
            default:     w_shift = 32'd0;
        endcase
        case (bus.exe_alu_op_i)
            ALU_OP_ADD, ALU_OP_ADDU: w_arith = w_sum;
            ALU_OP_SUB, ALU_OP_SUBU: w_arith = w_diff;
            ALU_OP_SLT:  w_arith = {31'd0, $signed(w_a) < $signed(w_b)};
            ALU_OP_SLTU: w_arith = {31'd0, w_a < w_b};
            default:     w_arith = 32'd0;
        endcase
    end

    always_comb begin
        if (bus.exe_alu_op_i == ALU_OP_MULT)
            w_prod = $signed({{32{w_a[31]}}, w_a}) * $signed({{32{w_b[31]}}, w_b});
        else
            w_prod = {32'd0, w_a} * {32'd0, w_b};
    end

`ifdef EXE_OVERFLOW_TRAP_EN
    assign w_ov = (bus.exe_alu_sel_i == ALU_SEL_ARITH) &&
                  (((bus.exe_alu_op_i == ALU_OP_ADD) && (w_a[31] == w_b[31]) && (w_sum[31]  != w_a[31])) ||
                   ((bus.exe_alu_op_i == ALU_OP_SUB) && (w_a[31] != w_b[31]) && (w_diff[31] != w_a[31])));
`else
    assign w_ov = 1'b0;
`endif

    always_comb begin
        bus.wreg_o  = bus.exe_wreg_i;
        bus.wdata_o = 32'd0;
        bus.whilo_o = 1'b0;
        bus.hi_o    = 32'd0;
        bus.lo_o    = 32'd0;
        case (bus.exe_alu_sel_i)
            ALU_SEL_NOP:   bus.wreg_o = 1'b0;
            ALU_SEL_LOGIC: bus.wdata_o = w_logic;
            ALU_SEL_SHIFT: bus.wdata_o = w_shift;
            ALU_SEL_ARITH: begin
                bus.wdata_o = w_arith;
                if (w_ov) bus.wreg_o = 1'b0;
            end
            ALU_SEL_MOVE: begin
                if (bus.exe_mf_hi_i)      bus.wdata_o = bus.hi_i;
                else if (bus.exe_mf_lo_i) bus.wdata_o = bus.lo_i;
                if (bus.exe_mt_hi_i) begin
                    bus.whilo_o = 1'b1;
                    bus.hi_o    = w_a;
                    bus.lo_o    = bus.lo_i;
                end else if (bus.exe_mt_lo_i) begin
                    bus.whilo_o = 1'b1;
                    bus.hi_o    = bus.hi_i;
                    bus.lo_o    = w_a;
                end
            end
            ALU_SEL_MULDIV: begin
                if (bus.exe_alu_op_i == ALU_OP_MULT || bus.exe_alu_op_i == ALU_OP_MULTU) begin
                    bus.whilo_o = 1'b1;
                    {bus.hi_o, bus.lo_o} = w_prod;
                end
            end
            default: bus.wreg_o = 1'b0;
        endcase
        if (w_div_done) begin
            bus.whilo_o = 1'b1;
            bus.hi_o    = w_div_r;
            bus.lo_o    = w_div_q;
        end
        if (rst) begin
            bus.wreg_o  = 1'b0;
            bus.whilo_o = 1'b0;
        end
    end

    assign bus.stall_req_o   = w_div_stall;
    assign bus.ov_o          = w_ov;
    assign bus.wd_o          = bus.exe_wd_i;
    assign bus.rmem_o        = bus.exe_rmem_i;
    assign bus.wmem_o        = bus.exe_wmem_i;
    assign bus.mem_io_addr_o = bus.exe_mem_io_addr_i;
    assign bus.mem_wdata_o   = w_b;
endmodule
`default_nettype wire

// File: tb/tb_exe_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_exe_stage
// Brief    : Scoreboard bench for exe_stage with directed, hand-computed vectors.
// Revision : 1.0
// ============================================================================
module tb_exe_stage;
    import exe_pkg::*;

    typedef struct {
        int          cyc;
        string       nm;
        logic        stall;
        logic        wreg;
        logic        chk_wdata;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        ov;
        logic [4:0]  wd;
        logic        rmem;
        logic        wmem;
        logic [31:0] addr;
        logic [31:0] mwd;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [4:0] wd_seq = 5'd0;
    exp_t q[$];
    exp_t e;
    logic bad;

    exe_stage_if bif();

    exe_stage #(.DIV_STEPS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops every expectation scheduled for the current cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            bad = (e.cyc != cyc);
            if (bif.stall_req_o !== e.stall || bif.wreg_o !== e.wreg || bif.whilo_o !== e.whilo ||
                bif.ov_o !== e.ov || bif.wd_o !== e.wd || bif.rmem_o !== e.rmem ||
                bif.wmem_o !== e.wmem || bif.mem_io_addr_o !== e.addr || bif.mem_wdata_o !== e.mwd)
                bad = 1'b1;
            if (e.chk_wdata && bif.wdata_o !== e.wdata) bad = 1'b1;
            if (e.whilo && (bif.hi_o !== e.hi || bif.lo_o !== e.lo)) bad = 1'b1;
            n_cmp = n_cmp + 1;
            if (bad) begin
                n_bad = n_bad + 1;
                $display("FAIL %s cyc=%0d: got stall=%b wreg=%b wd=%0d wdata=%h whilo=%b hi=%h lo=%h ov=%b; expected stall=%b wreg=%b wd=%0d wdata=%h whilo=%b hi=%h lo=%h ov=%b",
                         e.nm, cyc, bif.stall_req_o, bif.wreg_o, bif.wd_o, bif.wdata_o, bif.whilo_o,
                         bif.hi_o, bif.lo_o, bif.ov_o, e.stall, e.wreg, e.wd, e.wdata, e.whilo,
                         e.hi, e.lo, e.ov);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input alu_sel_e sel, input logic [7:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic wr);
        wd_seq                = wd_seq + 5'd1;
        bif.exe_alu_sel_i     = sel;
        bif.exe_alu_op_i      = op;
        bif.exe_reg1_i        = a;
        bif.exe_reg2_i        = b;
        bif.exe_wreg_i        = wr;
        bif.exe_wd_i          = wd_seq;
        bif.exe_rmem_i        = op[0];
        bif.exe_wmem_i        = op[1];
        bif.exe_mem_io_addr_i = a ^ 32'h0000_1000;
        bif.exe_mt_hi_i       = 1'b0;
        bif.exe_mt_lo_i       = 1'b0;
        bif.exe_mf_hi_i       = 1'b0;
        bif.exe_mf_lo_i       = 1'b0;
    endtask

    task automatic push(input string nm, input logic stall, input logic wreg, input logic chk_w,
                        input logic [31:0] wdata, input logic whilo, input logic [31:0] hi,
                        input logic [31:0] lo, input logic ov);
        exp_t x;
        x.cyc = cyc;  x.nm = nm;  x.stall = stall;  x.wreg = wreg;  x.chk_wdata = chk_w;
        x.wdata = wdata;  x.whilo = whilo;  x.hi = hi;  x.lo = lo;  x.ov = ov;
        x.wd = wd_seq;  x.rmem = bif.exe_alu_op_i[0];  x.wmem = bif.exe_alu_op_i[1];
        x.addr = bif.exe_reg1_i ^ 32'h0000_1000;  x.mwd = bif.exe_reg2_i;
        q.push_back(x);
    endtask

    task automatic alu(input string nm, input alu_sel_e sel, input logic [7:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] res);
        drive(sel, op, a, b, 1'b1);
        push(nm, 1'b0, 1'b1, 1'b1, res, 1'b0, 32'd0, 32'd0, 1'b0);
        tick();
    endtask

    task automatic run_div(input string nm, input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int n_stall,
                           input logic [31:0] hi, input logic [31:0] lo);
        drive(ALU_SEL_MULDIV, op, a, b, 1'b0);
        for (int i = 0; i < n_stall; i++) begin
            push({nm, "_stall"}, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
            tick();
        end
        push({nm, "_result"}, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, hi, lo, 1'b0);
        tick();
        drive(ALU_SEL_NOP, 8'h00, 32'd0, 32'd0, 1'b0);
        push({nm, "_after"}, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bif.flush_i = 1'b0;
        bif.stall_i = 1'b0;
        bif.hi_i    = 32'hAAAA_0001;
        bif.lo_i    = 32'h5555_0002;
        drive(ALU_SEL_MULDIV, ALU_OP_DIV, 32'd9, 32'd2, 1'b1);
        tick();
        for (int i = 0; i < 2; i++) begin
            push("reset", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
            tick();
        end
        rst = 1'b0;

        drive(ALU_SEL_NOP, ALU_OP_ADD, 32'd5, 32'd7, 1'b1);
        push("nop", 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        tick();

        alu("add",  ALU_SEL_ARITH, ALU_OP_ADD,  32'd5,         32'd7,         32'd12);
        alu("and",  ALU_SEL_LOGIC, ALU_OP_AND,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234);
        alu("or",   ALU_SEL_LOGIC, ALU_OP_OR,   32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFFF0_FFFF);
        alu("xor",  ALU_SEL_LOGIC, ALU_OP_XOR,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB);
        alu("nor",  ALU_SEL_LOGIC, ALU_OP_NOR,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'h000F_0000);
        alu("lui",  ALU_SEL_LOGIC, ALU_OP_LUI,  32'd0,         32'h0000_1234, 32'h1234_0000);
        alu("sll",  ALU_SEL_SHIFT, ALU_OP_SLL,  32'd4,         32'h0000_00F1, 32'h0000_0F10);
        alu("srl",  ALU_SEL_SHIFT, ALU_OP_SRL,  32'd4,         32'h8000_0010, 32'h0800_0001);
        alu("sra",  ALU_SEL_SHIFT, ALU_OP_SRA,  32'h0000_0024, 32'h8000_0010, 32'hF800_0001);
        alu("sub",  ALU_SEL_ARITH, ALU_OP_SUB,  32'd5,         32'd7,         32'hFFFF_FFFE);
        alu("subu", ALU_SEL_ARITH, ALU_OP_SUBU, 32'd5,         32'd7,         32'hFFFF_FFFE);
        alu("addu", ALU_SEL_ARITH, ALU_OP_ADDU, 32'hFFFF_FFFF, 32'd2,         32'd1);
        alu("slt",  ALU_SEL_ARITH, ALU_OP_SLT,  32'hFFFF_FFFF, 32'd1,         32'd1);
        alu("sltu", ALU_SEL_ARITH, ALU_OP_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0);

        drive(ALU_SEL_ARITH, ALU_OP_ADD, 32'h7FFF_FFFF, 32'd1, 1'b1);
`ifdef EXE_OVERFLOW_TRAP_EN
        push("add_ovf", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1);
`else
        push("add_ovf", 1'b0, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 32'd0, 32'd0, 1'b0);
`endif
        tick();

        drive(ALU_SEL_MOVE, ALU_OP_MFHI, 32'd0, 32'd0, 1'b1);
        bif.exe_mf_hi_i = 1'b1;
        push("mfhi", 1'b0, 1'b1, 1'b1, 32'hAAAA_0001, 1'b0, 32'd0, 32'd0, 1'b0);
        tick();
        drive(ALU_SEL_MOVE, ALU_OP_MFLO, 32'd0, 32'd0, 1'b1);
        bif.exe_mf_lo_i = 1'b1;
        push("mflo", 1'b0, 1'b1, 1'b1, 32'h5555_0002, 1'b0, 32'd0, 32'd0, 1'b0);
        tick();
        drive(ALU_SEL_MOVE, ALU_OP_MTHI, 32'h0000_1111, 32'd0, 1'b0);
        bif.exe_mt_hi_i = 1'b1;
        push("mthi", 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_1111, 32'h5555_0002, 1'b0);
        tick();
        drive(ALU_SEL_MOVE, ALU_OP_MTLO, 32'h0000_2222, 32'd0, 1'b0);
        bif.exe_mt_lo_i = 1'b1;
        push("mtlo", 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hAAAA_0001, 32'h0000_2222, 1'b0);
        tick();

        drive(ALU_SEL_MULDIV, ALU_OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
        push("mult", 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
        tick();
        drive(ALU_SEL_MULDIV, ALU_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        push("multu", 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        tick();

        run_div("div_neg7_2",   ALU_OP_DIV,  32'hFFFF_FFF9, 32'd2,         33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_div("divu_by_zero", ALU_OP_DIVU, 32'd10,        32'd0,         1,  32'd10,        32'hFFFF_FFFF);
        run_div("div_min_m1",   ALU_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0,         32'h8000_0000);
        run_div("div_7_neg2",   ALU_OP_DIV,  32'd7,         32'hFFFF_FFFE, 33, 32'd1,         32'hFFFF_FFFD);

        // Flush at BUSY cycle 10 must abort with no HI/LO write.
        drive(ALU_SEL_MULDIV, ALU_OP_DIVU, 32'd100, 32'd7, 1'b0);
        for (int i = 0; i < 10; i++) begin
            push("flush_busy", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
            tick();
        end
        bif.flush_i = 1'b1;
        push("flush_cycle", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        tick();
        bif.flush_i = 1'b0;
        drive(ALU_SEL_NOP, 8'h00, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            push("flush_idle", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
            tick();
        end

        // Reset mid-division behaves as a flush.
        drive(ALU_SEL_MULDIV, ALU_OP_DIVU, 32'd100, 32'd7, 1'b0);
        for (int i = 0; i < 5; i++) begin
            push("rst_busy", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
            tick();
        end
        rst = 1'b1;
        push("rst_cycle", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        tick();
        rst = 1'b0;
        drive(ALU_SEL_NOP, 8'h00, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            push("rst_idle", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
            tick();
        end

        // Downstream stall while in DONE holds the result without restarting.
        drive(ALU_SEL_MULDIV, ALU_OP_DIVU, 32'd100, 32'd7, 1'b0);
        for (int i = 0; i < 33; i++) begin
            push("hold_busy", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
            tick();
        end
        bif.stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push("hold_done", 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'd2, 32'd14, 1'b0);
            tick();
        end
        bif.stall_i = 1'b0;
        push("hold_release", 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'd2, 32'd14, 1'b0);
        tick();
        drive(ALU_SEL_NOP, 8'h00, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            push("hold_after", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
            tick();
        end

        tick();
        tick();
        if (q.size() != 0) begin
            n_cmp = n_cmp + 1;
            n_bad = n_bad + 1;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline. Sits directly downstream of the ID/EXE pipeline register and consumes its outputs.
- Computes ALU and shift results, single-cycle MULT/MULTU, and HI/LO moves.
- Runs an iterative 32-step radix-2 divider for DIV/DIVU and holds the pipeline through `stall_req_o` while it works.
- Passes write-back and memory-control fields on to the EXE/MEM register.

Parameters:
- DIV_STEPS, 32, number of divider iterations; fixed at 32, no other value supported.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- flush_i  in  1  pipeline flush; aborts any division
- stall_i  in  1  downstream stall; EXE/MEM is holding
- exe_alu_sel_i  in  3  operation class (package enum)
- exe_alu_op_i  in  8  operation code (package constants)
- exe_reg1_i  in  32  operand A (rs)
- exe_reg2_i  in  32  operand B (rt or immediate)
- exe_wreg_i  in  1  GPR write enable
- exe_wd_i  in  5  GPR destination
- exe_mt_hi_i, exe_mt_lo_i, exe_mf_hi_i, exe_mf_lo_i  in  1 each  HI/LO move flags
- exe_rmem_i, exe_wmem_i  in  1 each  load/store flags
- exe_mem_io_addr_i  in  32  memory address
- hi_i, lo_i  in  32 each  current HI/LO, already forwarded from MEM/WB
- wreg_o  out  1; wd_o  out  5; wdata_o  out  32  GPR write-back
- whilo_o  out  1; hi_o  out  32; lo_o  out  32  HI/LO write
- rmem_o, wmem_o  out  1 each; mem_io_addr_o  out  32; mem_wdata_o  out  32  (= reg2)
- stall_req_o  out  1  request to hold IF/ID/EXE
- ov_o  out  1  arithmetic overflow, only with the macro; otherwise tied to 0

Behaviour:
- All outputs are combinational from inputs plus divider state. Registered state is the divider FSM only.
- In reset (`rst`=1) the FSM goes to IDLE, the counter to 0, and the outputs are: `stall_req_o`=0, `whilo_o`=0, `wreg_o`=0.
- `alu_sel` classes:
  - NOP: all write enables 0, `wdata_o`=0.
  - LOGIC: AND/OR/XOR/NOR/LUI.
  - SHIFT: SLL/SRL/SRA using `reg1[4:0]` as the shift amount.
  - ARITH: ADD/ADDU/SUB/SUBU/SLT/SLTU. Results are 32-bit, wrap-around.
  - MOVE: MFHI → `wdata_o`=`hi_i`; MFLO → `wdata_o`=`lo_i`; MTHI → `whilo_o`=1, `hi_o`=reg1, `lo_o`=`lo_i`; MTLO is symmetric.
  - MULDIV: MULT/MULTU produce a 64-bit product in the same cycle; `hi_o`=[63:32], `lo_o`=[31:0], `whilo_o`=1.
- Divider FSM states: IDLE, BUSY, DONE.
  - IDLE → BUSY: on DIV/DIVU with `flush_i`=0 and divisor≠0. Latch |A| and |B| (raw values for DIVU) and the sign flags; counter←0. `stall_req_o`=1.
  - IDLE → DONE: divisor==0. Result fixed: quotient=0xFFFFFFFF, remainder=dividend. `stall_req_o`=1 for that cycle.
  - BUSY: one restoring-division step per cycle. `stall_req_o`=1. After 32 steps → DONE.
  - DONE: `stall_req_o`=0, `whilo_o`=1, `hi_o`=remainder, `lo_o`=quotient. Quotient is negated if the operand signs differ; remainder takes the dividend's sign.
  - DONE → IDLE when `stall_i`=0. If `stall_i`=1, stay in DONE holding the result; the same DIV must not restart.
- Non-zero divide latency: `stall_req_o` high for 33 cycles; result presented on the 34th.
- Edge case: 0x80000000 / -1 gives `lo_o`=0x80000000, `hi_o`=0, no exception.
- `flush_i` in any state → IDLE next cycle, `stall_req_o`=0 in the flush cycle, and no `whilo_o` is issued.
- `rst` mid-division behaves like `flush_i`.
- A non-DIV `alu_sel` arriving while in BUSY is impossible because upstream is held; it is ignored.
- Pass-through fields are asserted combinationally unchanged: `wd`, `rmem`, `wmem`, `mem_io_addr`.

Optional Feature:
- Macro: EXE_OVERFLOW_TRAP_EN.
- Defined: signed ADD/SUB overflow sets `ov_o`=1 and forces `wreg_o`=0 for that instruction.
- Undefined: `ov_o`=0 and ADD/SUB behave like ADDU/SUBU.

Decomposition:
- Package `exe_pkg`:
  - `alu_sel_e` enum (3-bit).
  - `ALU_OP_*` 8-bit constants.
  - `div_state_e` {IDLE, BUSY, DONE}.
- Sub-module `div_iter`: owns the FSM, counter, and 64-bit remainder/quotient register, with a start/abort/hold/done interface.
- `exe_stage` keeps the ALU and the output muxing.

Test Plan:
- ADD reg1=5, reg2=7, wreg=1, wd=3 → same cycle `wdata_o`=12, `wreg_o`=1, `wd_o`=3, `stall_req_o`=0.
- DIV reg1=-7 (0xFFFFFFF9), reg2=2 → `stall_req_o` high 33 cycles, then `lo_o`=0xFFFFFFFD, `hi_o`=0xFFFFFFFF, `whilo_o`=1 for one cycle.
- DIVU reg1=10, reg2=0 → one stall cycle, then `lo_o`=0xFFFFFFFF, `hi_o`=10.
- DIVU 100/7 with `flush_i` pulsed at BUSY cycle 10 → IDLE next cycle, `whilo_o` never asserted, `stall_req_o`=0.
- DIVU 100/7 with `stall_i`=1 for 3 cycles at DONE → `hi_o`=2, `lo_o`=14 held all 3 cycles, no restart.
- EXE_OVERFLOW_TRAP_EN, ADD 0x7FFFFFFF+1 → `ov_o`=1, `wreg_o`=0; with the macro undefined → `wdata_o`=0x80000000, `wreg_o`=1.
